// File: rtl/lcd_bus_writer.sv
// 8080-style write engine for a parallel TFT bus: a small FIFO of {rs, data, repeat}
// words feeds a strobe generator that drives cs_n/rs/wr_n/data with registered outputs.
module lcd_bus_writer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int T_SETUP    = 1,
  parameter int T_WR_LOW   = 2,
  parameter int T_WR_HIGH  = 2,
  parameter int T_CS_HOLD  = 1
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_rs,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [15:0]                   in_repeat,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          lcd_cs_n,
  output logic                          lcd_rs,
  output logic                          lcd_wr_n,
  output logic                          lcd_rd_n,
  output logic [DATA_W-1:0]             lcd_data_out,
  output logic                          lcd_data_oe,
  output logic [2:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 1 + DATA_W + 16;
  localparam int CW = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WR_LOW  = 3'd2,
    WR_HIGH = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [15:0]     rep_cnt;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_next;
  logic [EW-1:0]   head;
  logic            push, pop, rep_dec, fifo_empty;

  // Handshake: a word transfers on every clock edge where in_valid && in_ready are
  // both high. in_ready is a register derived from the FIFO level only, so a full
  // FIFO refuses a push even when a pop happens on the same edge.
  assign push       = in_valid && in_ready;
  assign fifo_empty = (fifo_level == '0);
  assign head       = mem[rd_ptr];
  assign level_next = fifo_level + LW'(push) - LW'(pop);

  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= {in_rs, in_data, in_repeat};
  end

  // Each timed state loads the down-counter with its duration minus one on entry.
  always_comb begin
    state_next = state;
    cnt_next   = (cnt != '0) ? cnt - CW'(1) : cnt;
    pop        = 1'b0;
    rep_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = SETUP;
          cnt_next   = CW'(T_SETUP - 1);
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_next = WR_LOW;
          cnt_next   = CW'(T_WR_LOW - 1);
        end
      end
      WR_LOW: begin
        if (cnt == '0) begin
          state_next = WR_HIGH;
          cnt_next   = CW'(T_WR_HIGH - 1);
        end
      end
      WR_HIGH: begin
        if (cnt == '0) begin
          if (rep_cnt != '0) begin
            rep_dec    = 1'b1;
            state_next = WR_LOW;
            cnt_next   = CW'(T_WR_LOW - 1);
          end else if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = SETUP;
            cnt_next   = CW'(T_SETUP - 1);
          end else begin
            state_next = HOLD;
            cnt_next   = CW'(T_CS_HOLD - 1);
          end
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = SETUP;
            cnt_next   = CW'(T_SETUP - 1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pin registers are loaded from the next state so they line up with the FSM state.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rep_cnt      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      in_ready     <= 1'b1;
      lcd_cs_n     <= 1'b1;
      lcd_wr_n     <= 1'b1;
      lcd_rs       <= 1'b0;
      lcd_data_out <= '0;
      lcd_data_oe  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      fifo_level <= level_next;
      in_ready   <= (level_next != LW'(FIFO_DEPTH));
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr       <= rd_ptr + AW'(1);
        rep_cnt      <= head[15:0];
        lcd_data_out <= head[16 +: DATA_W];
        lcd_rs       <= head[EW-1];
      end else if (rep_dec) begin
        rep_cnt <= rep_cnt - 16'd1;
      end
      lcd_cs_n    <= (state_next == IDLE);
      lcd_wr_n    <= (state_next != WR_LOW);
      lcd_data_oe <= (state_next != IDLE);
    end
  end

  assign lcd_rd_n  = 1'b1;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign dbg_state = state;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Bench for lcd_bus_writer: vector table, hand-written corner sequences, random words
// checked by a bus monitor against a word-level expectation queue.
module tb_lcd_bus_writer;

  localparam int DEPTH     = 16;
  localparam int T_SETUP   = 1;
  localparam int T_WR_LOW  = 2;
  localparam int T_WR_HIGH = 2;
  localparam int T_CS_HOLD = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_reset = 1'b1;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- main DUT ----------------
  logic        in_valid = 1'b0, in_rs = 1'b0;
  logic [15:0] in_data = '0, in_repeat = '0;
  logic        in_ready, busy, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data_oe;
  logic [4:0]  fifo_level;
  logic [15:0] lcd_data_out;
  logic [2:0]  dbg_state;

  lcd_bus_writer #(.DATA_W(16), .FIFO_DEPTH(DEPTH), .T_SETUP(T_SETUP), .T_WR_LOW(T_WR_LOW),
                   .T_WR_HIGH(T_WR_HIGH), .T_CS_HOLD(T_CS_HOLD)) u_dut (
    .clk_clk(clk), .reset_reset(reset_reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_data(in_data), .in_repeat(in_repeat), .busy(busy),
    .fifo_level(fifo_level), .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n),
    .lcd_rd_n(lcd_rd_n), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
    .dbg_state(dbg_state)
  );

  // ---------------- second DUT with alternate timing ----------------
  logic        b_valid = 1'b0;
  logic        b_rs_in = 1'b1;
  logic [15:0] b_data_in = 16'h5A5A, b_rep_in = '0;
  logic        b_ready, b_busy, b_cs_n, b_rs, b_wr_n, b_rd_n, b_oe;
  logic [4:0]  b_level;
  logic [15:0] b_data_out;
  logic [2:0]  b_state;

  lcd_bus_writer #(.DATA_W(16), .FIFO_DEPTH(DEPTH), .T_SETUP(3), .T_WR_LOW(1),
                   .T_WR_HIGH(1), .T_CS_HOLD(1)) u_dut6 (
    .clk_clk(clk), .reset_reset(reset_reset), .in_valid(b_valid), .in_ready(b_ready),
    .in_rs(b_rs_in), .in_data(b_data_in), .in_repeat(b_rep_in), .busy(b_busy),
    .fifo_level(b_level), .lcd_cs_n(b_cs_n), .lcd_rs(b_rs), .lcd_wr_n(b_wr_n),
    .lcd_rd_n(b_rd_n), .lcd_data_out(b_data_out), .lcd_data_oe(b_oe), .dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];   // {first_of_word, rs, data}, one entry per expected wr_n pulse
  int          acc_q[$];   // acceptance edge of the word each entry came from

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- bus monitor ----------------
  logic        mon_en = 1'b0;
  logic        prev_cs = 1'b1, prev_wr = 1'b1, prev_busy = 1'b0;
  logic        fall_rs;
  logic [15:0] fall_data;
  logic [17:0] ent;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, cs_low_len = 0, wr_fall_cyc = 0, last_rise_cyc = 0;
  int first_fall_cyc = 0, busy_fall_cyc = 0, wr_falls = 0, cs_windows = 0, pulses_in_win = 0;
  int max_level = 0;

  always @(negedge clk) begin
    int cyc, acc, gap, want;
    cyc = edge_cnt + 1;
    if (mon_en) begin
      check("oe_vs_cs", lcd_data_oe, !lcd_cs_n);
      check("rd_n_high", lcd_rd_n, 1);
      check("ready_vs_level", in_ready, fifo_level != DEPTH);
      check("level_le_depth", fifo_level <= DEPTH, 1);
      if (!lcd_wr_n) check("cs_low_in_strobe", lcd_cs_n, 0);
      if (!lcd_wr_n && !prev_wr) begin
        check("rs_stable_low", lcd_rs, fall_rs);
        check("data_stable_low", lcd_data_out, fall_data);
      end
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end
    if (prev_cs && !lcd_cs_n) begin
      cs_windows++;
      cs_fall_cyc   = cyc;
      pulses_in_win = 0;
      if (mon_en) begin
        if (acc_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_cs: cs_n fell at cycle %0d, required no activity", cyc);
        end else begin
          want = (acc_q[0] + 2 > cs_rise_cyc + 1) ? acc_q[0] + 2 : cs_rise_cyc + 1;
          check("cs_fall_latency", cyc, want);
        end
      end
    end
    if (!prev_cs && lcd_cs_n) begin
      cs_rise_cyc = cyc;
      cs_low_len  = cyc - cs_fall_cyc;
      if (mon_en) check("cs_hold_time", cyc - last_rise_cyc, T_WR_HIGH + T_CS_HOLD);
    end
    if (prev_wr && !lcd_wr_n) begin
      wr_falls++;
      wr_fall_cyc = cyc;
      fall_rs     = lcd_rs;
      fall_data   = lcd_data_out;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_pulse: got pulse at cycle %0d, required none", cyc);
        end else begin
          ent = exp_q.pop_front();
          acc = acc_q.pop_front();
          check("pulse_rs", lcd_rs, ent[16]);
          check("pulse_data", lcd_data_out, ent[15:0]);
          if (pulses_in_win == 0) begin
            check("first_in_window", ent[17], 1);
            check("setup_time", cyc - cs_fall_cyc, T_SETUP);
          end else if (!ent[17]) begin
            check("repeat_gap", cyc - last_rise_cyc, T_WR_HIGH);
          end else begin
            // word already visible at the end of WR_HIGH goes straight to SETUP, else via HOLD
            gap = (acc + 1 <= last_rise_cyc + T_WR_HIGH - 1) ? T_WR_HIGH + T_SETUP
                                                             : T_WR_HIGH + T_CS_HOLD + T_SETUP;
            check("word_gap", cyc - last_rise_cyc, gap);
          end
        end
      end
      if (pulses_in_win == 0) first_fall_cyc = cyc;
      pulses_in_win++;
    end
    if (!prev_wr && lcd_wr_n) begin
      last_rise_cyc = cyc;
      if (mon_en) begin
        check("wr_low_width", cyc - wr_fall_cyc, T_WR_LOW);
        check("rs_at_latch", lcd_rs, fall_rs);
        check("data_at_latch", lcd_data_out, fall_data);
      end
    end
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    prev_cs   = lcd_cs_n;
    prev_wr   = lcd_wr_n;
    prev_busy = busy;
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic rs, input logic [15:0] d, input logic [15:0] rep,
                      output int acc_edge);
    bit done;
    done      = 1'b0;
    acc_edge  = -1;
    in_valid  = 1'b1;
    in_rs     = rs;
    in_data   = d;
    in_repeat = rep;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc_edge = edge_cnt;
        done     = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL push_timeout: word 0x%0h not accepted, required acceptance", d);
    end else begin
      for (int r = 0; r <= int'(rep); r++) begin
        exp_q.push_back({(r == 0), rs, d});
        acc_q.push_back(acc_edge);
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 6000 && !done; t++) begin
      @(negedge clk);
      if (!busy && lcd_cs_n) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL %s_idle_timeout: still busy, required idle", tag);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic        rs;
    logic [15:0] data;
    logic [15:0] rep;
    int          exp_pulses;
    int          exp_cs_low;
  } vec_t;

  vec_t tbl[6];
  int   k, k0, p0, w0, a, a16, a17, kb, c, cs_first, wr_first, wr_low_n, cs_low_n, f0;
  bit   data_ok, hit;

  initial begin
    // cs_n low time = T_SETUP + (rep+1)*(T_WR_LOW+T_WR_HIGH) + T_CS_HOLD
    tbl[0] = '{1'b0, 16'h002C, 16'd0, 1, 6};
    tbl[1] = '{1'b1, 16'h1234, 16'd0, 1, 6};
    tbl[2] = '{1'b1, 16'hF800, 16'd3, 4, 18};
    tbl[3] = '{1'b0, 16'hA5A5, 16'd1, 2, 10};
    tbl[4] = '{1'b1, 16'hFFFF, 16'd2, 3, 14};
    tbl[5] = '{1'b1, 16'h0000, 16'd7, 8, 34};

    repeat (3) @(posedge clk);
    #1 reset_reset = 1'b0;
    @(negedge clk);
    check("rst_cs_n", lcd_cs_n, 1);
    check("rst_wr_n", lcd_wr_n, 1);
    check("rst_rd_n", lcd_rd_n, 1);
    check("rst_rs", lcd_rs, 0);
    check("rst_data", lcd_data_out, 0);
    check("rst_oe", lcd_data_oe, 0);
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // isolated words from the table
    for (int i = 0; i < 6; i++) begin
      p0 = wr_falls;
      w0 = cs_windows;
      push(tbl[i].rs, tbl[i].data, tbl[i].rep, k);
      wait_idle("tbl");
      check("tbl_pulses", wr_falls - p0, tbl[i].exp_pulses);
      check("tbl_windows", cs_windows - w0, 1);
      check("tbl_cs_fall", cs_fall_cyc, k + 2);
      check("tbl_first_wr_fall", first_fall_cyc, k + 2 + T_SETUP);
      check("tbl_cs_low", cs_low_len, tbl[i].exp_cs_low);
      check("tbl_busy_fall", busy_fall_cyc, k + 2 + tbl[i].exp_cs_low);
      check("tbl_sb_drained", exp_q.size(), 0);
    end

    // command then data back to back: one cs_n window, one HOLD at the end
    p0 = wr_falls;
    w0 = cs_windows;
    push(1'b0, 16'h002A, 16'd0, k);
    push(1'b1, 16'h1234, 16'd0, a);
    wait_idle("b2b");
    check("b2b_accept_gap", a - k, 1);
    check("b2b_pulses", wr_falls - p0, 2);
    check("b2b_windows", cs_windows - w0, 1);
    check("b2b_cs_low", cs_low_len, 11);
    check("b2b_sb_drained", exp_q.size(), 0);

    // long burst while the FIFO fills up and overflows by one
    max_level = 0;
    push(1'b1, 16'h07E0, 16'd100, k0);
    for (int i = 1; i <= 16; i++) begin
      push(1'(i & 1), 16'(16'h1000 + i), 16'd0, a);
      if (i == 16) a16 = a;
    end
    check("fill_no_gap", a16 - k0, 16);
    @(negedge clk);
    check("fill_ready_low", in_ready, 0);
    check("fill_level_full", fifo_level, DEPTH);
    @(posedge clk);
    #1;
    push(1'b0, 16'h1011, 16'd0, a17);
    // the first pop after the burst ends its last WR_HIGH; in_ready returns on the next cycle
    check("fill_17th_accept", a17, k0 + 2 + T_SETUP + 101 * (T_WR_LOW + T_WR_HIGH));
    wait_idle("fill");
    check("fill_max_level", max_level, DEPTH);
    check("fill_sb_drained", exp_q.size(), 0);

    // random words with random idle gaps
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
      push(1'($urandom_range(0, 1)), 16'($urandom),
           ($urandom_range(0, 9) == 0) ? 16'($urandom_range(4, 20)) : 16'($urandom_range(0, 2)), a);
    end
    wait_idle("rand");
    check("rand_sb_drained", exp_q.size(), 0);

    // alternate timing instance: single write
    b_valid = 1'b1;
    @(posedge clk);
    #1;
    b_valid  = 1'b0;
    kb       = edge_cnt;
    cs_first = -1;
    wr_first = -1;
    wr_low_n = 0;
    cs_low_n = 0;
    data_ok  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      c = edge_cnt + 1;
      if (!b_cs_n) begin
        cs_low_n++;
        if (cs_first < 0) cs_first = c;
        if (b_data_out !== 16'h5A5A || b_rs !== 1'b1 || b_oe !== 1'b1) data_ok = 1'b0;
      end
      if (!b_wr_n) begin
        wr_low_n++;
        if (wr_first < 0) wr_first = c;
      end
    end
    check("t6_cs_fall", cs_first, kb + 2);
    check("t6_setup", wr_first - cs_first, 3);
    check("t6_wr_low", wr_low_n, 1);
    check("t6_cs_low", cs_low_n, 6);
    check("t6_bus_values", data_ok, 1);
    check("t6_idle", b_busy, 0);
    @(posedge clk);
    #1;

    // reset in the middle of WR_LOW of a repeat burst with words queued behind it
    mon_en = 1'b0;
    p0 = wr_falls;
    push(1'b1, 16'h001F, 16'd10, k);
    push(1'b0, 16'h0029, 16'd0, a);
    push(1'b1, 16'hBEEF, 16'd0, a);
    hit = 1'b0;
    for (int t = 0; t < 300 && !hit; t++) begin
      @(negedge clk);
      if (wr_falls - p0 >= 3 && !lcd_wr_n) hit = 1'b1;
    end
    check("rst_mid_reached", hit, 1);
    reset_reset = 1'b1;
    @(posedge clk);
    #1 reset_reset = 1'b0;
    @(negedge clk);
    check("rst_mid_wr_n", lcd_wr_n, 1);
    check("rst_mid_cs_n", lcd_cs_n, 1);
    check("rst_mid_oe", lcd_data_oe, 0);
    check("rst_mid_level", fifo_level, 0);
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_busy", busy, 0);
    f0 = wr_falls;
    repeat (40) @(negedge clk);
    check("rst_mid_no_pulses", wr_falls - f0, 0);
    check("rst_mid_cs_idle", lcd_cs_n, 1);
    exp_q.delete();
    acc_q.delete();
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // recovery after reset
    p0 = wr_falls;
    push(1'b1, 16'h3C3C, 16'd1, k);
    wait_idle("recover");
    check("recover_pulses", wr_falls - p0, 2);
    check("recover_cs_low", cs_low_len, 10);
    check("recover_sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
